// File: rtl/seq_stream_ctrl.sv
// seq_stream_ctrl: streams a latched pattern LSB-first into a serial detector and collects its hits.
// Optional SEQ_MOORE_ALIGN_EN: adds a DRAIN cycle and attributes det_out to the previous bit.
module seq_stream_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] first_hit,
  output logic [WIDTH-1:0] hit_map,
  output logic             det_clr,
  output logic             det_en,
  output logic             det_in,
  input  logic             det_out
);
`ifdef SEQ_MOORE_ALIGN_EN
  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DONE} state_t;
`endif
  state_t st, nxt;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] idx, sidx;
  logic last, samp, accept;
  assign last   = idx == CNT_W'(WIDTH - 1);
  assign accept = (st == IDLE || st == DONE) && start;
`ifdef SEQ_MOORE_ALIGN_EN
  // registered detector: the flag seen now belongs to the bit driven one cycle earlier
  assign samp = ((st == SHIFT && idx != '0) || st == DRAIN) && det_out && !abort;
  assign sidx = idx - 1'b1;
  assign busy = st == CLEAR || st == SHIFT || st == DRAIN;
`else
  assign samp = st == SHIFT && det_out && !abort;
  assign sidx = idx;
  assign busy = st == CLEAR || st == SHIFT;
`endif
  assign done    = st == DONE;
  assign det_en  = st == SHIFT;
  assign det_in  = det_en & shreg[0];
  assign det_clr = !rst || st == CLEAR;
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = start ? CLEAR : IDLE;
      CLEAR:   nxt = abort ? IDLE : SHIFT;
`ifdef SEQ_MOORE_ALIGN_EN
      SHIFT:   nxt = abort ? IDLE : last ? DRAIN : SHIFT;
      DRAIN:   nxt = abort ? IDLE : DONE;
`else
      SHIFT:   nxt = abort ? IDLE : last ? DONE : SHIFT;
`endif
      DONE:    nxt = start ? CLEAR : IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= IDLE;
      shreg     <= '0;
      idx       <= '0;
      hit_count <= '0;
      first_hit <= '0;
      hit_map   <= '0;
    end else begin
      st <= nxt;
      if (accept) begin
        shreg     <= data;
        idx       <= '0;
        hit_count <= '0;
        first_hit <= CNT_W'(WIDTH);
        hit_map   <= '0;
      end else if (st == SHIFT) begin
        shreg <= shreg >> 1;
        idx   <= idx + 1'b1;
      end
      if (samp) begin
        hit_count <= &hit_count ? hit_count : hit_count + 1'b1;
        hit_map   <= hit_map | (WIDTH'(1) << sidx);
        if (first_hit == CNT_W'(WIDTH)) first_hit <= sidx;
      end
    end
  end
endmodule

// File: tb/tb_seq_stream_ctrl.sv
// tb_seq_stream_ctrl: scoreboard bench with an overlapping "11" detector model (Mealy, or registered under SEQ_MOORE_ALIGN_EN).
module tb_seq_stream_ctrl;
`ifdef SEQ_MOORE_ALIGN_EN
  localparam int LAT = 19;
`else
  localparam int LAT = 18;
`endif
  localparam logic [15:0] BASIC = 16'b0110010111011110;
  logic clk = 0, rst = 0, start = 0, abort = 0;
  logic [15:0] data = '0;
  logic busy, done, det_clr, det_en, det_in, det_out, prev;
  logic [4:0] hit_count, first_hit;
  logic [15:0] hit_map;
  typedef struct {int hc; int fh; int hm; int dc;} exp_t;
  exp_t q[$];
  exp_t me;
  int cyc = 0, checks = 0, errs = 0, acc;

  seq_stream_ctrl #(.WIDTH(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .data(data),
    .busy(busy), .done(done), .hit_count(hit_count), .first_hit(first_hit),
    .hit_map(hit_map), .det_clr(det_clr), .det_en(det_en), .det_in(det_in),
    .det_out(det_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) prev <= det_clr ? 1'b0 : det_in;
`ifdef SEQ_MOORE_ALIGN_EN
  always @(posedge clk) det_out <= det_clr ? 1'b0 : det_in & prev;
`else
  assign det_out = det_in & prev;
`endif

  function automatic void chk(string n, longint a, longint e);
    checks++;
    if (a != e) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (done) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        me = q.pop_front();
        chk("hit_count", hit_count, me.hc);
        chk("first_hit", first_hit, me.fh);
        chk("hit_map", hit_map, me.hm);
        chk("done_cycle", cyc, me.dc);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] d, input bit push, input int hc, input int fh, input int hm, output int a);
    tick();
    data = d;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    a = cyc;
    if (push) q.push_back('{hc, fh, hm, a + LAT});
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && q.size() > 0; i++) tick();
    chk("drain_timeout", q.size(), 0);
    repeat (4) tick();
  endtask

  task automatic chk_reset_vals(string n);
    chk({n, "_busy"}, busy, 0);
    chk({n, "_done"}, done, 0);
    chk({n, "_det_en"}, det_en, 0);
    chk({n, "_det_in"}, det_in, 0);
    chk({n, "_hit_count"}, hit_count, 0);
    chk({n, "_hit_map"}, hit_map, 0);
    chk({n, "_first_hit"}, first_hit, 0);
    chk({n, "_det_clr"}, det_clr, 1);
  endtask

  initial begin
    #1 chk_reset_vals("reset");
    repeat (2) tick();
    rst = 1;
    tick();
    chk("idle_det_clr", det_clr, 0);

    // basic run and all-zeros run
    issue(BASIC, 1, 6, 2, 'h419C, acc);
    drain();
    issue(16'h0000, 1, 0, 16, 0, acc);
    drain();

    // back-to-back: start held through DONE
    tick();
    data = 16'hFFFF;
    start = 1;
    @(posedge clk);
    #1 acc = cyc;
    q.push_back('{15, 1, 'hFFFE, acc + LAT});
    q.push_back('{15, 1, 'hFFFE, acc + 2 * LAT});
    while (cyc < acc + LAT) tick();
    @(posedge clk);
    #1 start = 0;
    tick();
    chk("b2b_no_gap_busy", busy, 1);
    drain();

    // start while busy is ignored, data change must not be relatched
    issue(BASIC, 1, 6, 2, 'h419C, acc);
    while (cyc < acc + 5) tick();
    data = 16'hFFFF;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    drain();
    repeat (25) tick();
    chk("busy_after_ignored_start", busy, 0);

    // abort at SHIFT idx 6
    issue(BASIC, 0, 0, 0, 0, acc);
    while (cyc < acc + 8) tick();
    chk("abort_det_en_before", det_en, 1);
    abort = 1;
    @(posedge clk);
    #1 abort = 0;
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_det_en", det_en, 0);
    chk("abort_hit_count", hit_count, 3);
    chk("abort_hit_map", hit_map, 'h001C);
    chk("abort_first_hit", first_hit, 2);
    repeat (25) tick();

    // abort in IDLE has no effect on held results
    abort = 1;
    tick();
    abort = 0;
    chk("idle_abort_hit_count", hit_count, 3);

    // reset mid-SHIFT
    issue(BASIC, 0, 0, 0, 0, acc);
    while (cyc < acc + 8) tick();
    rst = 0;
    #1 chk_reset_vals("midrst");
    tick();
    rst = 1;
    repeat (3) tick();

    // normal run after reset recovery
    issue(BASIC, 1, 6, 2, 'h419C, acc);
    drain();
    chk("final_queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule

// File: doc/seq_stream_ctrl.md
Name: seq_stream_ctrl

Overview:
- Controller that sequences a serial bit-stream sequence detector.
- Accepts a WIDTH-bit pattern word on a start pulse, clears the detector, then drives it one bit per clock, LSB first.
- Collects the detector's hit output into a hit count, a first-hit index and a per-bit hit map.
- Sits between a host/register interface and a detector instance; the detector's own port set is (clk, rst, in, out).

Parameters:
- WIDTH, 16, number of pattern bits streamed per run (2..64).
- CNT_W, 5, width of hit_count/first_hit; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request a run; accepted only when busy=0.
- abort  input  1  synchronous abort of an in-progress run.
- data  input  WIDTH  pattern word; sampled on the start-accept edge.
- busy  output  1  high in CLEAR, SHIFT and DRAIN.
- done  output  1  one-cycle pulse when results are valid.
- hit_count  output  CNT_W  number of detector hits in the run.
- first_hit  output  CNT_W  index of the first hit; WIDTH if there were none.
- hit_map  output  WIDTH  bit i set if the detector hit on stream bit i.
- det_clr  output  1  active-high clear to the detector's rst.
- det_en  output  1  high while det_in carries a valid stream bit.
- det_in  output  1  serial bit to the detector.
- det_out  input  1  detector hit flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - State is IDLE.
  - busy, done, det_en, det_in, hit_count, hit_map, first_hit are all 0.
  - det_clr is 1 while rst=0, so the detector is held cleared.
- States: IDLE, CLEAR, SHIFT, DRAIN (present only with the optional feature), DONE.
- IDLE, start=1: latch data into the shift register, set idx=0, clear hit_count and hit_map, set first_hit=WIDTH, go to CLEAR.
- CLEAR (1 cycle): det_clr=1, det_en=0. Go to SHIFT.
- SHIFT (WIDTH cycles):
  - det_en=1, det_in=shreg[0].
  - On each edge with det_out=1: hit_count+1, hit_map[idx]=1, and first_hit=idx if first_hit==WIDTH.
  - Then shreg shifts right and idx increments.
  - On the edge where idx==WIDTH-1, go to DONE.
- DONE (1 cycle): done=1, busy=0. Next state is IDLE, or CLEAR if start=1 in this cycle (back-to-back runs).
- Latency: done is high in cycle WIDTH+2 after the start-accept edge (18 for WIDTH=16).
- start while busy=1 is ignored and not queued.
- abort=1 in CLEAR, SHIFT or DRAIN: go to IDLE on the next edge, done is not pulsed, det_en drops, and the partial results remain visible.
- abort in IDLE or DONE has no effect. If start and abort are both high in IDLE, start wins.
- hit_count saturates at 2^CNT_W-1.
- Results hold from DONE until the next start is accepted.
- det_in is 0 whenever det_en=0.
- rst asserted mid-run aborts immediately and restores all reset values.

Optional Feature:
- Macro: SEQ_MOORE_ALIGN_EN.
- Defined (for registered-output detectors):
  - det_out is attributed to the bit driven in the previous cycle.
  - The hit for bit i is sampled on the edge after bit i.
  - A single DRAIN cycle (det_en=0, busy=1) follows SHIFT to sample the hit for the last bit.
  - Nothing is sampled on the first SHIFT edge.
  - Start-to-done latency becomes WIDTH+3.
- Undefined: det_out is sampled on the same edge as its det_in bit, there is no DRAIN state, and latency is WIDTH+2.

Test Plan:
- Basic run:
  - Stimulus: reset, then start with data=16'b0110010111011110 against a bench "11" overlapping Mealy detector model.
  - Required: done at cycle 18, hit_count=6, first_hit=2, hit_map=16'h419C.
- All zeros: data=16'h0000 -> hit_count=0, first_hit=16, hit_map=0, done at cycle 18.
- Saturation and back-to-back:
  - Stimulus: data=16'hFFFF, then start held high through DONE.
  - Required: hit_count=15 (first bit gives no hit after the clear), first_hit=1, hit_map=16'hFFFE; the second run starts with no IDLE gap.
- start while busy: start pulsed at cycle 5 of a run -> ignored, and exactly one done pulse occurs.
- Abort:
  - Stimulus: abort at SHIFT idx=6 of the basic pattern.
  - Required: no done pulse, busy=0 next cycle, hit_count=3, hit_map=16'h001C.
- Reset and Moore build:
  - Reset mid-SHIFT -> all outputs at reset values immediately, det_clr=1.
  - With SEQ_MOORE_ALIGN_EN and a registered-output model, the basic run gives identical results with done at cycle 19.
